// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its PC source mux.
package fetch_pkg;

    localparam int INSTR_W = 32;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } fetch_state_t;

    localparam logic [1:0] PC_SEQ    = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    localparam logic [1:0] PC_HOLD   = 2'b11;

endpackage

// File: rtl/pc_next_mux.sv
// Next-PC source selector: sequential, branch target, jump target or hold.
module pc_next_mux
    import fetch_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [1:0]        pc_sel,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] pc_plus4,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic [ADDR_W-1:0] jump_target,
    output logic [ADDR_W-1:0] pc_next
);

    always_comb begin
        pc_next = pc;
        case (pc_sel)
            PC_SEQ:    pc_next = pc_plus4;
            PC_BRANCH: pc_next = branch_target;
            PC_JUMP:   pc_next = jump_target;
            default:   pc_next = pc;
        endcase
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// PC owner and IR capture for the multicycle core's instruction-memory read path.
// Optional misaligned-fetch trap enabled by defining FETCH_ALIGN_CHECK_EN.
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                MEM_WAIT = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_start,
    input  logic              pc_load,
    input  logic [1:0]        pc_sel,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic [ADDR_W-1:0] jump_target,
    output logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] instruction,
    output logic [DATA_W-1:0] ir,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              fetch_busy,
    output logic              fetch_done,
    output logic              fetch_fault
);

    localparam logic [3:0] WCNT_INIT = 4'(MEM_WAIT);

    fetch_state_t      r_state, w_state_nxt;
    logic [3:0]        r_wcnt;
    logic [ADDR_W-1:0] r_pc;
    logic [DATA_W-1:0] r_ir;
    logic              r_done;
    logic              r_fault;
    logic [ADDR_W-1:0] w_pc_plus4;
    logic [ADDR_W-1:0] w_pc_next;
    logic              w_misalign;
    logic              w_start;
    logic              w_fault_req;
    logic              w_capture;

    assign w_pc_plus4 = r_pc + ADDR_W'(4);

`ifdef FETCH_ALIGN_CHECK_EN
    assign w_misalign = |r_pc[1:0];
`else
    assign w_misalign = 1'b0;
`endif

    pc_next_mux #(.ADDR_W(ADDR_W)) u_pc_next_mux (
        .pc_sel        (pc_sel),
        .pc            (r_pc),
        .pc_plus4      (w_pc_plus4),
        .branch_target (branch_target),
        .jump_target   (jump_target),
        .pc_next       (w_pc_next)
    );

    // pc_load has priority over fetch_start; a dropped start is not remembered.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_fault_req = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            IDLE: begin
                if (!pc_load && fetch_start) begin
                    if (w_misalign) begin
                        w_fault_req = 1'b1;
                    end else begin
                        w_start     = 1'b1;
                        w_state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (r_wcnt == 4'd0) begin
                    w_capture   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_wcnt  <= 4'd0;
            r_pc    <= RESET_PC;
            r_ir    <= '0;
            r_done  <= 1'b0;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_capture;
            r_fault <= w_fault_req;
            if (w_start) begin
                r_wcnt <= WCNT_INIT;
            end else if (r_state == WAIT && r_wcnt != 4'd0) begin
                r_wcnt <= r_wcnt - 4'd1;
            end
            if (w_capture) begin
                r_ir <= instruction;
                r_pc <= w_pc_plus4;
            end else if (r_state == IDLE && pc_load) begin
                r_pc <= w_pc_next;
            end
        end
    end

    assign address     = r_pc;
    assign pc          = r_pc;
    assign pc_plus4    = w_pc_plus4;
    assign ir          = r_ir;
    assign fetch_busy  = (r_state != IDLE);
    assign fetch_done  = r_done;
    assign fetch_fault = r_fault;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: two instances (MEM_WAIT 0 and 2) share one stimulus
// stream and are compared every cycle against a transaction-level reference model.
module tb_instruction_fetch_unit;

`ifdef FETCH_ALIGN_CHECK_EN
    localparam bit ALIGN_CHK = 1'b1;
`else
    localparam bit ALIGN_CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fs = 1'b0, pl = 1'b0;
    logic [1:0]  sel = 2'b00;
    logic [31:0] bt = '0, jt = '0;

    logic [31:0] a0, i0, ir0, pc0, pp0;
    logic [31:0] a1, i1, ir1, pc1, pp1;
    logic        busy0, done0, flt0, busy1, done1, flt1;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    int          mw[2] = '{0, 2};
    int          m_cap[2];       // edge number of the pending capture, -1 when idle
    logic [31:0] m_pc[2], m_ir[2];
    logic        m_done[2], m_fault[2];

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h11111111;
            32'h4:   return 32'h22222222;
            32'h8:   return 32'h33333333;
            default: return (a * 32'h9E3779B1) ^ 32'hA5A50000;
        endcase
    endfunction

    assign i0 = mem_rd(a0);
    assign i1 = mem_rd(a1);

    instruction_fetch_unit #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'h0), .MEM_WAIT(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .fetch_start(fs), .pc_load(pl), .pc_sel(sel),
        .branch_target(bt), .jump_target(jt), .address(a0), .instruction(i0),
        .ir(ir0), .pc(pc0), .pc_plus4(pp0), .fetch_busy(busy0), .fetch_done(done0),
        .fetch_fault(flt0)
    );

    instruction_fetch_unit #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'h0), .MEM_WAIT(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .fetch_start(fs), .pc_load(pl), .pc_sel(sel),
        .branch_target(bt), .jump_target(jt), .address(a1), .instruction(i1),
        .ir(ir1), .pc(pc1), .pc_plus4(pp1), .fetch_busy(busy1), .fetch_done(done1),
        .fetch_fault(flt1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_dut(input int k, input logic [31:0] a, input logic [31:0] irv,
                             input logic [31:0] pcv, input logic [31:0] ppv,
                             input logic b, input logic d, input logic f);
        string s;
        s = $sformatf("mw%0d", mw[k]);
        chk({s, ".pc"},       pcv, m_pc[k]);
        chk({s, ".address"},  a,   m_pc[k]);
        chk({s, ".pc_plus4"}, ppv, m_pc[k] + 32'd4);
        chk({s, ".ir"},       irv, m_ir[k]);
        chk({s, ".busy"},     32'(b), 32'(m_cap[k] >= 0));
        chk({s, ".done"},     32'(d), 32'(m_done[k]));
        chk({s, ".fault"},    32'(f), 32'(m_fault[k]));
    endtask

    task automatic check_all();
        check_dut(0, a0, ir0, pc0, pp0, busy0, done0, flt0);
        check_dut(1, a1, ir1, pc1, pp1, busy1, done1, flt1);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_cap[k] = -1; m_pc[k] = 32'h0; m_ir[k] = 32'h0;
            m_done[k] = 1'b0; m_fault[k] = 1'b0;
        end
    endtask

    // One rising edge as seen by a transaction-level view of the fetch unit.
    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            m_done[k]  = 1'b0;
            m_fault[k] = 1'b0;
            if (m_cap[k] == cyc) begin
                m_ir[k]   = mem_rd(m_pc[k]);
                m_pc[k]   = m_pc[k] + 32'd4;
                m_done[k] = 1'b1;
                m_cap[k]  = -1;
            end else if (m_cap[k] < 0) begin
                if (pl) begin
                    if (sel == 2'b00)      m_pc[k] = m_pc[k] + 32'd4;
                    else if (sel == 2'b01) m_pc[k] = bt;
                    else if (sel == 2'b10) m_pc[k] = jt;
                end else if (fs) begin
                    if (ALIGN_CHK && m_pc[k][1:0] != 2'b00) m_fault[k] = 1'b1;
                    else m_cap[k] = cyc + 1 + mw[k];
                end
            end
        end
    endtask

    task automatic step(input logic f, input logic p, input logic [1:0] s,
                        input logic [31:0] b, input logic [31:0] j);
        fs = f; pl = p; sel = s; bt = b; jt = j;
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    endtask

    // Asynchronous reset asserted between edges, held across one edge.
    task automatic do_reset();
        fs = 1'b0; pl = 1'b0;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        cyc++;
        #1;
        check_all();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] r, t;
        model_reset();
        #2;
        do_reset();

        // Back-to-back fetches, each start in the done cycle of the MEM_WAIT=0 unit.
        step(1, 0, 2'b00, 0, 0);
        step(0, 0, 2'b00, 0, 0);
        step(1, 0, 2'b00, 0, 0);
        step(0, 0, 2'b00, 0, 0);
        step(1, 0, 2'b00, 0, 0);
        step(0, 0, 2'b00, 0, 0);
        idle(4);

        // Branch then fetch.
        step(0, 1, 2'b01, 32'h20, 32'h0);
        step(1, 0, 2'b00, 0, 0);
        idle(4);

        // Start and pc_load pulsed while the wait-state unit is busy.
        step(1, 0, 2'b00, 0, 0);
        step(1, 0, 2'b00, 0, 0);
        step(0, 1, 2'b10, 32'h0, 32'h100);
        idle(4);

        // Hold and sequential pc_load codes.
        step(0, 1, 2'b11, 32'h0, 32'h0);
        step(0, 1, 2'b00, 32'h0, 32'h0);

        // Wrap at the top of the address space.
        step(0, 1, 2'b10, 32'h0, 32'hFFFFFFFC);
        step(1, 0, 2'b00, 0, 0);
        idle(4);

        // Simultaneous pc_load and fetch_start: load wins, no fetch.
        step(1, 1, 2'b10, 32'h0, 32'h40);
        idle(2);

        // Unaligned target then fetch.
        step(0, 1, 2'b01, 32'h22, 32'h0);
        step(1, 0, 2'b00, 0, 0);
        idle(4);

        // Reset in the middle of a wait-state fetch.
        step(0, 1, 2'b01, 32'h8, 32'h0);
        step(1, 0, 2'b00, 0, 0);
        step(0, 0, 2'b00, 0, 0);
        do_reset();
        idle(4);

        for (int i = 0; i < 400; i++) begin
            r = $urandom();
            case ($urandom_range(0, 3))
                0:       t = r & 32'hFFFFFFFC;
                1:       t = 32'hFFFFFFFC;
                2:       t = r;
                default: t = r & 32'h000000FC;
            endcase
            if ($urandom_range(0, 59) == 0) do_reset();
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                 2'($urandom_range(0, 3)), t, t ^ 32'h00000F00);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
